// File: rtl/phase_readout.sv
// phase_readout: counts sync'd osc_a/osc_b disagreement over WINDOW samples and reports spin/tie/stuck.
// Optional PHASE_COUNT_OUT_EN exposes the final mismatch count on mismatch_count.
module phase_readout #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW        = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic osc_a,
  input  logic osc_b,
  input  logic start,
  output logic busy,
  output logic result_valid,
  input  logic result_ready,
  output logic spin,
  output logic tie,
  output logic stuck_a,
  output logic stuck_b
`ifdef PHASE_COUNT_OUT_EN
  ,
  output logic [$clog2(WINDOW+1)-1:0] mismatch_count
`endif
);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic [SW-1:0] settle_q;
  logic [CW-1:0] sample_q, mis_q, mis_d, count_q;
  logic [CW:0] mis2_d;
  logic sa, sb, ref_a_q, ref_b_q, tog_a_q, tog_b_q, tog_a_d, tog_b_d, last_d;
  logic busy_q, valid_q, spin_q, tie_q, stuck_a_q, stuck_b_q;
  assign sa = sync_a_q[SYNC_STAGES-1];
  assign sb = sync_b_q[SYNC_STAGES-1];
  // Next-sample values include the current cycle so the final sample counts too
  always_comb begin
    mis_d   = mis_q + CW'(sa ^ sb);
    tog_a_d = tog_a_q | (sa != ref_a_q);
    tog_b_d = tog_b_q | (sb != ref_b_q);
    mis2_d  = {mis_d, 1'b0};
    last_d  = sample_q == CW'(WINDOW - 1);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      settle_q  <= '0;
      sample_q  <= '0;
      mis_q     <= '0;
      count_q   <= '0;
      ref_a_q   <= 1'b0;
      ref_b_q   <= 1'b0;
      tog_a_q   <= 1'b0;
      tog_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      spin_q    <= 1'b0;
      tie_q     <= 1'b0;
      stuck_a_q <= 1'b0;
      stuck_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], osc_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], osc_b};
      case (state_q)
        IDLE: if (start) begin
          state_q  <= SETTLE;
          settle_q <= '0;
          busy_q   <= 1'b1;
        end
        SETTLE: if (settle_q == SW'(SETTLE_CYCLES)) begin
          state_q  <= MEASURE;
          sample_q <= '0;
          mis_q    <= '0;
          tog_a_q  <= 1'b0;
          tog_b_q  <= 1'b0;
          ref_a_q  <= sa;
          ref_b_q  <= sb;
        end else begin
          settle_q <= settle_q + 1'b1;
        end
        MEASURE: begin
          mis_q    <= mis_d;
          tog_a_q  <= tog_a_d;
          tog_b_q  <= tog_b_d;
          sample_q <= sample_q + 1'b1;
          if (last_d) begin
            state_q   <= DONE;
            valid_q   <= 1'b1;
            spin_q    <= mis2_d < (CW+1)'(WINDOW);
            tie_q     <= mis2_d == (CW+1)'(WINDOW);
            stuck_a_q <= ~tog_a_d;
            stuck_b_q <= ~tog_b_d;
            count_q   <= mis_d;
          end
        end
        DONE: if (result_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign spin         = spin_q;
  assign tie          = tie_q;
  assign stuck_a      = stuck_a_q;
  assign stuck_b      = stuck_b_q;
`ifdef PHASE_COUNT_OUT_EN
  assign mismatch_count = count_q;
`else
  logic unused_count;
  assign unused_count = ^count_q;
`endif
endmodule

// File: tb/tb_phase_readout.sv
// tb_phase_readout: directed table-driven bench for phase_readout with WINDOW=16, SETTLE_CYCLES=4.
module tb_phase_readout;
  localparam int W = 16;
  localparam int S = 4;
  localparam int LAT = S + W + 1;
  logic clk = 1'b0, rstn = 1'b0, osc_a = 1'b0, osc_b = 1'b0, start = 1'b0, result_ready = 1'b0;
  logic busy, result_valid, spin, tie, stuck_a, stuck_b;
`ifdef PHASE_COUNT_OUT_EN
  logic [4:0] mismatch_count;
`endif
  int n_chk = 0, n_fail = 0;
  int mode = 0;
  int unsigned cyc = 0;

  phase_readout #(.SYNC_STAGES(2), .SETTLE_CYCLES(S), .WINDOW(W)) dut (
    .clk(clk), .rstn(rstn), .osc_a(osc_a), .osc_b(osc_b), .start(start),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .spin(spin), .tie(tie), .stuck_a(stuck_a), .stuck_b(stuck_b)
`ifdef PHASE_COUNT_OUT_EN
    , .mismatch_count(mismatch_count)
`endif
  );

  always #5 clk = ~clk;

  // Oscillator waveforms: 0 same, 1 anti, 2 quadrature, 3 a stuck low, 4 both stuck high
  always @(negedge clk) begin
    cyc = cyc + 1;
    osc_a = mode == 3 ? 1'b0 : mode == 4 ? 1'b1 : mode == 2 ? ((cyc / 4) % 2 != 0) : ((cyc / 3) % 2 != 0);
    osc_b = mode == 0 ? osc_a : mode == 1 ? ~osc_a : mode == 2 ? (((cyc + 6) / 4) % 2 != 0) :
            mode == 3 ? ((cyc / 4) % 2 != 0) : 1'b1;
  end

  typedef struct {
    int   mode;
    logic spin, tie, sa, sb;
    int   cnt;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(result_valid), 0);
    chk({tag, "_spin"}, 32'(spin), 0);
    chk({tag, "_tie"}, 32'(tie), 0);
    chk({tag, "_stuck_a"}, 32'(stuck_a), 0);
    chk({tag, "_stuck_b"}, 32'(stuck_b), 0);
`ifdef PHASE_COUNT_OUT_EN
    chk({tag, "_count"}, 32'(mismatch_count), 0);
`endif
  endtask

  // Pulse start, then count edges after E0 until result_valid; inj>0 re-pulses start at that edge
  task automatic start_wait(input int inj, output int lat);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = (lat == inj);
      if (result_valid) break;
    end
    start = 1'b0;
  endtask

  task automatic accept();
    @(negedge clk) result_ready = 1'b1;
    @(negedge clk) result_ready = 1'b0;
    chk("valid_drop", 32'(result_valid), 0);
    chk("busy_drop", 32'(busy), 0);
  endtask

  task automatic run_vec(input int idx);
    int lat;
    mode = vecs[idx].mode;
    repeat (4) @(negedge clk);
    start_wait(0, lat);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(LAT));
    chk($sformatf("v%0d_spin", idx), 32'(spin), 32'(vecs[idx].spin));
    chk($sformatf("v%0d_tie", idx), 32'(tie), 32'(vecs[idx].tie));
    chk($sformatf("v%0d_stuck_a", idx), 32'(stuck_a), 32'(vecs[idx].sa));
    chk($sformatf("v%0d_stuck_b", idx), 32'(stuck_b), 32'(vecs[idx].sb));
`ifdef PHASE_COUNT_OUT_EN
    chk($sformatf("v%0d_count", idx), 32'(mismatch_count), 32'(vecs[idx].cnt));
`endif
    accept();
    chk($sformatf("v%0d_spin_hold", idx), 32'(spin), 32'(vecs[idx].spin));
  endtask

  initial begin
    int lat;
    vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    vecs[2] = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 8};
    vecs[3] = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 8};
    vecs[4] = '{4, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(i);

    // Handshake: start during MEASURE and DONE ignored, result held while ready low
    mode = 1;
    repeat (4) @(negedge clk);
    start_wait(10, lat);
    chk("hs_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      chk("hs_valid_hold", 32'(result_valid), 1);
      chk("hs_busy_hold", 32'(busy), 1);
      chk("hs_spin_hold", 32'(spin), 0);
      @(negedge clk);
    end
    start = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    result_ready = 1'b0;
    chk("hs_accept_valid", 32'(result_valid), 0);
    chk("hs_accept_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("hs_start_ignored", 32'(busy), 0);

    // Reset mid-measurement: leave spin=1 from a prior run so clearing is visible
    run_vec(0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk) rstn = 1'b1;
    run_vec(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
